// File: rtl/sram_result_reader_pkg.sv
// rtl/sram_result_reader_pkg.sv - shared types and constants for the SRAM result reader
package sram_result_reader_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width able to hold 0..depth inclusive (full count of a power-of-two FIFO)
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_result_reader_sync_fifo.sv
// rtl/sram_result_reader_sync_fifo.sv - synchronous FIFO buffering returned SRAM words
module sram_result_reader_sync_fifo
  import sram_result_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W_DEF,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only honoured when a pop frees a slot the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage write; the head entry is held untouched until it is popped
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/sram_result_reader.sv
// rtl/sram_result_reader.sv - drains a block of SRAM result words into a valid/ready stream; RESULT_READER_CHECKSUM_EN adds an XOR checksum output
module sram_result_reader
  import sram_result_reader_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] word_count_i,
  output logic [ADDR_W-1:0] read_address_o,
  input  logic [DATA_W-1:0] read_bus_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
`ifdef RESULT_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum_o,
`endif
  output logic              done_o
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic [ADDR_W-1:0] deliv_q, deliv_d;
  logic              done_q, done_d;
  logic [READ_LATENCY-1:0] tok_q;

  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              issue;
  logic              start_acc;

  assign push        = tok_q[READ_LATENCY-1];
  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;
  assign out_last_o  = out_valid_o && (deliv_q == word_count_q - ADDR_W'(1));
  assign busy_o      = (state_q != ST_IDLE) || done_q;
  assign done_o      = done_q;

  // The address port only moves on an issue; otherwise it repeats the last issued address
  assign read_address_o = issue ? next_addr_q : last_addr_q;

  // Count read tokens still travelling through the latency pipeline
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CNT_W'(tok_q[i]);
    end
  end

  // Credit: reads in flight plus buffered words, less the word leaving this cycle, must leave a free slot
  always_comb begin
    credit_used = (CNT_W+1)'(in_flight) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop);
    credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);
  end

  // Next-state and issue control
  always_comb begin
    state_d      = state_q;
    next_addr_d  = next_addr_q;
    last_addr_d  = last_addr_q;
    remain_d     = remain_q;
    word_count_d = word_count_q;
    deliv_d      = pop ? deliv_q + ADDR_W'(1) : deliv_q;
    done_d       = 1'b0;
    issue        = 1'b0;
    start_acc    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // done_q still high means the previous block is finishing; hold off one more cycle
        if (start_i && !done_q) begin
          start_acc    = 1'b1;
          next_addr_d  = base_addr_i;
          remain_d     = word_count_i;
          word_count_d = word_count_i;
          deliv_d      = '0;
          state_d      = (word_count_i == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue       = 1'b1;
          last_addr_d = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(1);
          remain_d    = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last_o) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      next_addr_q  <= '0;
      last_addr_q  <= '0;
      remain_q     <= '0;
      word_count_q <= '0;
      deliv_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      last_addr_q  <= last_addr_d;
      remain_q     <= remain_d;
      word_count_q <= word_count_d;
      deliv_q      <= deliv_d;
      done_q       <= done_d;
    end
  end

  // Token pipeline matching the SRAM read latency; clearing it on reset drops in-flight data
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tok_q <= '0;
    end else begin
      tok_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tok_q[i] <= tok_q[i-1];
      end
    end
  end

  sram_result_reader_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .push_i      (push),
    .push_data_i (read_bus_i),
    .pop_i       (pop),
    .head_o      (out_data_o),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i) !(push && fifo_full && !pop));

`ifdef RESULT_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Running XOR of delivered words; frozen after the last transfer until the next block starts
  always_ff @(posedge clock_i) begin
    if (reset_i || start_acc) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ out_data_o;
    end
  end

  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_sram_result_reader.sv
// tb/tb_sram_result_reader.sv - randomized self-checking bench for sram_result_reader
`timescale 1ns/1ps
module tb_sram_result_reader;

  parameter int RL = 1;
  parameter int FD = 4;
  localparam int DW = 128;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic [AW-1:0] read_address;
  logic [DW-1:0] read_bus;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef RESULT_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  sram_result_reader #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start),
    .base_addr_i    (base_addr),
    .word_count_i   (word_count),
    .read_address_o (read_address),
    .read_bus_i     (read_bus),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_last_o     (out_last),
    .busy_o         (busy),
`ifdef RESULT_READER_CHECKSUM_EN
    .checksum_o     (checksum),
`endif
    .done_o         (done)
  );

  // SRAM model: word for the address presented in cycle t appears in cycle t+RL
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= mem[read_address];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign read_bus = pipe[RL-1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stream monitor
  logic [DW-1:0] got_q [$];
  logic          last_q [$];
  int            done_cnt = 0;
  int            valid_cnt = 0;
  int            done_cyc = 0;
  int            cyc_g = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, data_prev);
      end
      if (out_valid) valid_cnt <= valid_cnt + 1;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc_g;
      end
      stall_prev <= out_valid && !out_ready;
      data_prev  <= out_data;
    end
  end

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_block(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                           input int mode, input bit timing, input bit inject);
    int c;
    int dn0;
    int v0;
    int start_cyc;
    logic [DW-1:0] xsum;
    got_q.delete();
    last_q.delete();
    dn0 = done_cnt;
    v0  = valid_cnt;
    xsum = '0;
    @(posedge clk); #1;
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    out_ready  = rdy(mode, 0);
    start_cyc  = cyc_g;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = AW'($urandom);
    word_count = AW'($urandom);
    c = 1;
    while (done_cnt == dn0 && c < 4000) begin
      if (inject && c == 2) begin
        start      = 1'b1;
        base_addr  = 16'h4000;
        word_count = 16'd9;
      end
      out_ready = rdy(mode, c);
      @(negedge clk);
      if (timing) begin
        if (c == 1) check("busy_set", busy, 1'b1);
        if (c <= 4) check("issue_addr", read_address, AW'(base + AW'(c - 1)));
        if (c == RL + 1) check("valid_early", out_valid, 1'b0);
        if (c == RL + 2) check("valid_first", out_valid, 1'b1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
    end
    check("done_seen", done_cnt == dn0 + 1, 1'b1);
    @(negedge clk);
    check("busy_clear", busy, 1'b0);
    if (cnt == 0) begin
      check("done_lat", done_cyc - start_cyc, 2);
      check("no_valid", valid_cnt - v0, 0);
    end
    check("word_cnt", got_q.size(), cnt);
    for (int i = 0; i < got_q.size() && i < int'(cnt); i++) begin
      check("data", got_q[i], mem[AW'(base + AW'(i))]);
      check("last", last_q[i], i == int'(cnt) - 1);
      xsum = xsum ^ mem[AW'(base + AW'(i))];
    end
`ifdef RESULT_READER_CHECKSUM_EN
    check("checksum", checksum, xsum);
`endif
    repeat (4) @(negedge clk);
    check("no_extra_done", done_cnt, dn0 + 1);
    check("idle_valid", out_valid, 1'b0);
  endtask

  initial begin
    int c;
    int dn0;
    logic [DW-1:0] w1;
    logic [DW-1:0] w3;
    for (int i = 0; i < 65536; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", read_address, '0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) mem[16'h10 + i] = {4{8'h10 + 8'(i), 8'hA5, 8'h5A, 8'(i)}};
    run_block(16'h0010, 16'd4, 0, 1'b1, 1'b0);
    run_block(16'h0010, 16'd4, 1, 1'b0, 1'b0);
    run_block(16'hFFFE, 16'd4, 0, 1'b1, 1'b0);
    run_block(16'h0030, 16'd0, 0, 1'b0, 1'b1);
    run_block(16'h0020, 16'd3, 0, 1'b0, 1'b1);

    // Abort a block after two deliveries
    got_q.delete();
    dn0 = done_cnt;
    @(posedge clk); #1;
    base_addr = 16'h0100;
    word_count = 16'd8;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (got_q.size() < 2 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("abort_reached", got_q.size() >= 2, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    mem[0] = {$urandom, $urandom, $urandom, $urandom};
    mem[1] = {$urandom, $urandom, $urandom, $urandom};
    run_block(16'h0000, 16'd2, 0, 1'b0, 1'b0);
    check("abort_no_done", done_cnt, dn0 + 1);

`ifdef RESULT_READER_CHECKSUM_EN
    w1 = {4{32'h1111_1111}};
    w3 = {4{32'h3333_3333}};
    mem[16'h200] = w1;
    mem[16'h201] = w3;
    mem[16'h202] = w3;
    run_block(16'h0200, 16'd3, 2, 1'b0, 1'b0);
    check("checksum_fixed", checksum, w1);
`else
    w1 = '0;
    w3 = '0;
`endif

    for (int k = 0; k < 12; k++) begin
      run_block(AW'($urandom), AW'($urandom_range(1, 24)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_result_reader.md
Name: sram_result_reader

Overview:
Read-side counterpart of the datapath's result writes into the 2R1W SRAM. It drains a contiguous block of 128-bit result words through one SRAM read port and presents them as a valid/ready output stream. It sits beside the result SRAM (M4) and replaces the bench-only memory dump with a synthesizable unload path to the host or output logic. Read issue is pipelined, and a small FIFO absorbs SRAM read latency under back-pressure.

Parameters:
DATA_W, 128, SRAM word width
ADDR_W, 16, SRAM address width
READ_LATENCY, 1, cycles from ReadAddress to valid ReadBus (1..3)
FIFO_DEPTH, 4, output buffer entries; must be >= READ_LATENCY+1, power of two

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; accepted only when busy=0
base_addr  in  ADDR_W  first word address, sampled on accepted start
word_count  in  ADDR_W  number of words to read, sampled on accepted start
ReadAddress  out  ADDR_W  SRAM read-port address
ReadBus  in  DATA_W  SRAM read-port data
out_data  out  DATA_W  stream data (FIFO head)
out_valid  out  1  stream valid
out_ready  in  1  stream ready from consumer
out_last  out  1  high with the final word of the block
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset values: ReadAddress=0, out_valid=0, out_last=0, busy=0, done=0, FIFO empty, issue counters=0, latency pipeline valids cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when start=1, latch base_addr and word_count and set busy=1 in the next cycle. If word_count=0, go to DONE; otherwise go to ISSUE. start is ignored while busy=1.
- ISSUE: issue one read per cycle while (in_flight + fifo_count) < FIFO_DEPTH. Issuing drives ReadAddress=next_addr and pushes a valid token into a READ_LATENCY-deep shift register. Afterwards next_addr increments modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000. After word_count issues, go to DRAIN.
- Returning data: the token exits the shift register exactly READ_LATENCY cycles after issue. ReadBus is then written into the FIFO. The credit check guarantees the FIFO never overflows; overflow is a design error and is asserted in simulation.
- Stream: out_valid = FIFO not empty. A transfer occurs when out_valid && out_ready. Once out_valid is asserted, out_data must stay stable until the transfer. A FIFO push and pop in the same cycle are allowed; the count is unchanged. If the FIFO is empty, the write-through word appears on out_valid one cycle later (no bypass).
- out_last = out_valid && (this word is the word_count-th delivered word).
- DRAIN: wait for the last word's transfer, then go to DONE.
- DONE: done=1 for one cycle, then busy=0 and return to IDLE. In the same cycle that done is high, start is not accepted; it is accepted the following cycle.
- Minimum latency: the first out_valid occurs READ_LATENCY+2 cycles after the start pulse. With out_ready held at 1, throughput is 1 word per cycle.
- ReadAddress holds its last value when not issuing; the SRAM read has no side effects.
- Reset mid-operation: everything returns to reset values next cycle, in-flight read data is discarded, and no done pulse is generated.

Optional Feature:
RESULT_READER_CHECKSUM_EN
- With the macro: adds output checksum[DATA_W-1:0]. It is the XOR of every word transferred in the block, cleared on accepted start and on reset, and is valid and stable from the done pulse until the next accepted start.
- Without the macro: no port and no logic.

Decomposition:
- Shared package: FSM state enum (IDLE/ISSUE/DRAIN/DONE); DATA_W/ADDR_W defaults; a count-width helper constant clog2(FIFO_DEPTH)+1.
- One sub-module, sync_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/count/full/empty, same clock and reset. The latency shift register and the FSM stay in the top module.

Test Plan:
- Preload 0x10..0x13 with distinct patterns; start with base=0x0010, count=4, out_ready=1. Expect ReadAddress 0x10,0x11,0x12,0x13 on consecutive cycles and 4 words in order. out_last is high on the 4th word only, done pulses once, then busy=0.
- Same block with out_ready toggling 1,0,0,1 repeating. Expect in-order data, out_data stable while stalled, no FIFO overflow assertion, and at most FIFO_DEPTH outstanding reads.
- base=0xFFFE, count=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001; all data correct.
- count=0 -> no reads, out_valid never asserts, done pulses 2 cycles after start. A start pulse while busy=1 is ignored, with no change to the address or count.
- Assert reset after 2 of 8 words are delivered. Next cycle expect out_valid=0, busy=0, done=0. A new start with base=0x0000, count=2 delivers exactly 2 fresh words.
- RESULT_READER_CHECKSUM_EN, words 0x1…, 0x3…, 0x3… -> checksum = 0x1… at done. Rerun with READ_LATENCY=3 and FIFO_DEPTH=4 and confirm identical output.
